// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch counter held as four BCD digits.
// Counts seconds from the divider's 1 Hz wave in run mode, and bumps the selected
// field from the 2 Hz wave in adjust mode. A synchronized pause button toggles
// a freeze flag. Outputs feed the seven-segment display mux directly.

// One BCD field (tens:ones) that increments on inc and wraps MAX -> 0.
// at_max flags the terminal value so the caller can build a carry.
module stopwatch_bcd_field #(
    parameter int MAX = 59
) (
    input  logic       master,
    input  logic       rst,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       at_max
);
    localparam logic [3:0] MAX_T = 4'(MAX / 10);
    localparam logic [3:0] MAX_O = 4'(MAX % 10);

    // Terminal value, compared digit-wise so no binary conversion is needed
    always_comb begin
        at_max = (tens == MAX_T) && (ones == MAX_O);
    end

    // BCD increment: ones roll 9 -> 0 into tens; whole field wraps at MAX
    always_ff @(posedge master or negedge rst) begin
        if (!rst) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (inc) begin
            if (at_max) begin
                tens <= 4'd0;
                ones <= 4'd0;
            end else if (ones == 4'd9) begin
                tens <= tens + 4'd1;
                ones <= 4'd0;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end
endmodule

module stopwatch_counter #(
    parameter int SEC_MAX = 59,
    parameter int MIN_MAX = 59
) (
    input  logic       master,
    input  logic       rst,
    input  logic       t1Hz,
    input  logic       t2Hz,
    input  logic       adj,
    input  logic       sel,
    input  logic       pause,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       paused
);
    localparam int NUM_FLD = 2;   // field 0 = seconds, field 1 = minutes

    logic                          t1_q, t2_q;
    logic                          tick1, tick2;
    logic [2:0]                    pause_pipe;
    logic                          ptog;
    logic                          count_en;
    logic [NUM_FLD-1:0]            fld_inc;
    logic [NUM_FLD-1:0]            fld_max;
    logic [NUM_FLD-1:0][3:0]       fld_tens;
    logic [NUM_FLD-1:0][3:0]       fld_ones;

    // Divider edge history; resets high so a level already high at release is not a tick
    always_ff @(posedge master or negedge rst) begin
        if (!rst) begin
            t1_q <= 1'b1;
            t2_q <= 1'b1;
        end else begin
            t1_q <= t1Hz;
            t2_q <= t2Hz;
        end
    end

    // Pause button: two sync flops plus one history flop for rising-edge detect
    always_ff @(posedge master or negedge rst) begin
        if (!rst) pause_pipe <= 3'b000;
        else      pause_pipe <= {pause_pipe[1:0], pause};
    end

    // Single-cycle strobes from rising edges
    always_comb begin
        tick1 = t1Hz & ~t1_q;
        tick2 = t2Hz & ~t2_q;
        ptog  = pause_pipe[1] & ~pause_pipe[2];
    end

    // Freeze flag; a held button only produces one edge, hence one toggle
    always_ff @(posedge master or negedge rst) begin
        if (!rst)      paused <= 1'b0;
        else if (ptog) paused <= ~paused;
    end

    // Increment steering. Run mode uses the pre-toggle paused value, so a tick
    // coinciding with a pause press still counts. Adjust mode never carries.
    always_comb begin
        count_en   = ~adj & tick1 & ~paused;
        fld_inc[0] = adj ? (tick2 &  sel) : count_en;
        fld_inc[1] = adj ? (tick2 & ~sel) : (count_en & fld_max[0]);
    end

    generate
        for (genvar i = 0; i < NUM_FLD; i++) begin : g_fld
            stopwatch_bcd_field #(
                .MAX ((i == 0) ? SEC_MAX : MIN_MAX)
            ) u_fld (
                .master (master),
                .rst    (rst),
                .inc    (fld_inc[i]),
                .tens   (fld_tens[i]),
                .ones   (fld_ones[i]),
                .at_max (fld_max[i])
            );
        end
    endgenerate

    // Fields are already registered; just fan them out to named digits
    always_comb begin
        sec_tens = fld_tens[0];
        sec_ones = fld_ones[0];
        min_tens = fld_tens[1];
        min_ones = fld_ones[1];
    end
endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter: vector table, directed corner
// sequences, and a randomized run against a seconds-count reference model.
module tb_stopwatch_counter;
    logic       master, rst;
    logic       t1Hz, t2Hz, adj, sel, pause;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       paused;
    logic [15:0] digits;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int       m_tot;
    bit       m_paused, m_t1p, m_t2p;
    bit [2:0] m_ph;

    typedef struct {
        logic        t1, t2, a, s;
        logic [15:0] exp;
    } vec_t;
    vec_t vt[12];

    stopwatch_counter dut (
        .master   (master),
        .rst      (rst),
        .t1Hz     (t1Hz),
        .t2Hz     (t2Hz),
        .adj      (adj),
        .sel      (sel),
        .pause    (pause),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .paused   (paused)
    );

    assign digits = {min_tens, min_ones, sec_tens, sec_ones};

    initial begin
        master = 1'b0;
        forever #5 master = ~master;
    end

    function automatic logic [15:0] bcd(input int m, input int s);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ends at a falling edge with reset just released and all inputs low
    task automatic do_reset();
        @(negedge master);
        rst = 1'b0;
        t1Hz = 1'b0; t2Hz = 1'b0; adj = 1'b0; sel = 1'b0; pause = 1'b0;
        @(negedge master);
        rst = 1'b1;
    endtask

    task automatic pulse1(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge master); t1Hz = 1'b1;
            @(negedge master); t1Hz = 1'b0;
        end
    endtask

    task automatic pulse2(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge master); t2Hz = 1'b1;
            @(negedge master); t2Hz = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_tot = 0; m_paused = 0; m_t1p = 1; m_t2p = 1; m_ph = 3'b000;
    endtask

    // one master edge of the reference: time kept as total seconds
    task automatic model_step(input bit t1, input bit t2, input bit a, input bit s, input bit p);
        bit tk1, tk2, tog;
        int mm, ss;
        tk1 = t1 & ~m_t1p;
        tk2 = t2 & ~m_t2p;
        tog = m_ph[1] & ~m_ph[2];
        mm  = m_tot / 60;
        ss  = m_tot % 60;
        if (!a) begin
            if (tk1 && !m_paused) m_tot = (m_tot + 1) % 3600;
        end else if (tk2) begin
            if (s) m_tot = mm * 60 + (ss + 1) % 60;
            else   m_tot = ((mm + 1) % 60) * 60 + ss;
        end
        if (tog) m_paused = !m_paused;
        m_ph  = {m_ph[1:0], p};
        m_t1p = t1;
        m_t2p = t2;
    endtask

    initial begin
        rst = 1'b1; t1Hz = 1'b0; t2Hz = 1'b0; adj = 1'b0; sel = 1'b0; pause = 1'b0;

        vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0001};
        vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0001};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0002};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0002};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0002};
        vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0003};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0003};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0103};
        vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0104};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0104};

        // reset state
        do_reset();
        #1;
        check("reset_digits", 32'(digits), 32'h0);
        check("reset_paused", 32'(paused), 32'h0);

        // vector table, one master edge per entry
        for (int i = 0; i < 12; i++) begin
            t1Hz = vt[i].t1; t2Hz = vt[i].t2; adj = vt[i].a; sel = vt[i].s;
            @(negedge master);
            check($sformatf("vec%0d", i), 32'(digits), 32'(vt[i].exp));
        end

        // 61 seconds
        do_reset();
        pulse1(61);
        check("run_61", 32'(digits), 32'(bcd(1, 1)));
        check("run_61_paused", 32'(paused), 32'h0);

        // full-range wrap
        do_reset();
        pulse1(3599);
        check("run_5959", 32'(digits), 32'(bcd(59, 59)));
        pulse1(1);
        check("wrap_0000", 32'(digits), 32'(bcd(0, 0)));

        // pause latency, freeze, held button, resume
        do_reset();
        pulse1(10);
        pause = 1'b1;
        @(negedge master);
        @(negedge master);
        check("pause_edge2", 32'(paused), 32'h0);
        @(negedge master);
        check("pause_edge3", 32'(paused), 32'h1);
        pulse1(5);
        check("paused_frozen", 32'(digits), 32'(bcd(0, 10)));
        check("paused_held", 32'(paused), 32'h1);
        pause = 1'b0;
        repeat (4) @(negedge master);
        pause = 1'b1;
        repeat (4) @(negedge master);
        check("resume", 32'(paused), 32'h0);
        pulse1(1);
        check("resume_tick", 32'(digits), 32'(bcd(0, 11)));
        pause = 1'b0;
        repeat (4) @(negedge master);

        // adjust: seconds wrap without carry, then minutes wrap, t1 ignored
        do_reset();
        pulse1(178);
        check("adj_start", 32'(digits), 32'(bcd(2, 58)));
        adj = 1'b1; sel = 1'b1;
        pulse2(3);
        check("adj_sec", 32'(digits), 32'(bcd(2, 1)));
        sel = 1'b0;
        for (int k = 0; k < 58; k++) begin
            pulse2(1);
            if (k % 10 == 0) pulse1(1);
        end
        pulse1(3);
        check("adj_min", 32'(digits), 32'(bcd(0, 1)));
        adj = 1'b0;

        // ptog and tick1 on the same edge
        do_reset();
        pulse1(5);
        pause = 1'b1;
        @(negedge master);
        @(negedge master);
        t1Hz = 1'b1;
        @(negedge master);
        t1Hz = 1'b0;
        check("simul_digits", 32'(digits), 32'(bcd(0, 6)));
        check("simul_paused", 32'(paused), 32'h1);
        pulse1(3);
        check("simul_frozen", 32'(digits), 32'(bcd(0, 6)));
        pause = 1'b0;

        // asynchronous reset between edges, release with t1Hz high
        do_reset();
        pulse1(754);
        check("pre_async", 32'(digits), 32'(bcd(12, 34)));
        @(negedge master);
        #2 rst = 1'b0;
        t1Hz = 1'b1;
        #1;
        check("async_digits", 32'(digits), 32'h0);
        check("async_paused", 32'(paused), 32'h0);
        @(negedge master);
        rst = 1'b1;
        repeat (3) @(negedge master);
        check("release_high", 32'(digits), 32'h0);
        t1Hz = 1'b0;
        @(negedge master);
        t1Hz = 1'b1;
        @(negedge master);
        check("release_next", 32'(digits), 32'(bcd(0, 1)));
        t1Hz = 1'b0;

        // randomized run against the model
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            t1Hz = 1'($urandom_range(0, 1));
            t2Hz = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) adj = ~adj;
            if ($urandom_range(0, 9) == 0)  sel = ~sel;
            if ($urandom_range(0, 14) == 0) pause = ~pause;
            model_step(t1Hz, t2Hz, adj, sel, pause);
            @(negedge master);
            check("rand_digits", 32'(digits), 32'(bcd(m_tot / 60, m_tot % 60)));
            check("rand_paused", 32'(paused), 32'(m_paused));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
